gcd_stein: RTL and testbench

Iterative binary (Stein) greatest-common-divisor engine with a start/busy/done handshake. It pairs with the LCM unit in the same arithmetic cluster; since lcm·gcd = n1·n2, it lets the datapath check or derive LCM results. Each pass uses only shifts, compares and one subtract, so the critical path is one WIDTH-bit subtract/compare. A saturating cycle counter is exported for performance checks.

---
 rtl/gcd_if.sv | 17 +
 rtl/gcd_stein.sv | 148 ++++++++++++++
 tb/tb_gcd_stein.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_if.sv
// Request/response bundle for the binary GCD engine: operands and start in,
// busy/done handshake plus registered result and cycle count out.
interface gcd_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cycles;

  modport master (output start, n1, n2, input busy, done, result, cycles);
  modport slave  (input start, n1, n2, output busy, done, result, cycles);
endinterface

// File: rtl/gcd_stein.sv
// Iterative binary (Stein) GCD: shift out common factors of two, strip odd
// parts, subtract until equal, then restore the common power of two.
module gcd_stein #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic  clk,
  input logic  rst,
  gcd_if.slave bus
);
  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPECIAL = 3'd1,
    COMMON  = 3'd2,
    ODD_A   = 3'd3,
    ODD_B   = 3'd4,
    SUB     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
  logic [K_W-1:0]   k_r, k_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [CNT_W-1:0] cycles_r, cycles_s;
  logic             busy_r, busy_s, done_r, done_s;

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cycles = cycles_r;

  // Next-state, datapath and output decode for the GCD sequencer
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    k_s      = k_r;
    result_s = result_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          a_s     = bus.n1;
          b_s     = bus.n2;
          k_s     = '0;
          state_s = SPECIAL;
        end else begin
          state_s = IDLE;
        end
      end
      SPECIAL: begin
        // a==0 also covers gcd(0,0)=0
        if (a_r == '0) begin
          result_s = b_r;
          state_s  = DONE;
        end else if (b_r == '0) begin
          result_s = a_r;
          state_s  = DONE;
        end else begin
          state_s = COMMON;
        end
      end
      COMMON: begin
        if (!a_r[0] && !b_r[0]) begin
          a_s = a_r >> 1;
          b_s = b_r >> 1;
          k_s = k_r + K_W'(1);
        end else begin
          state_s = ODD_A;
        end
      end
      ODD_A: begin
        if (!a_r[0]) begin
          a_s = a_r >> 1;
        end else begin
          state_s = ODD_B;
        end
      end
      ODD_B: begin
        if (!b_r[0]) begin
          b_s = b_r >> 1;
        end else begin
          state_s = SUB;
        end
      end
      SUB: begin
        if (a_r == b_r) begin
          result_s = a_r << k_r;
          state_s  = DONE;
        end else if (a_r < b_r) begin
          b_s     = b_r - a_r;
          state_s = ODD_B;
        end else begin
          a_s     = b_r;
          b_s     = a_r - b_r;
          state_s = ODD_B;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Counter restarts at 1 on the accepting edge and saturates while busy
    if (state_r == IDLE) begin
      cnt_s = bus.start ? CNT_W'(1) : cnt_r;
    end else if (cnt_r != '1) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end

    cycles_s = (state_s == DONE) ? cnt_s : cycles_r;
    busy_s   = (state_s != IDLE);
    done_s   = (state_s == DONE);
  end

  // State, datapath and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      k_r      <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      cycles_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      k_r      <= k_s;
      cnt_r    <= cnt_s;
      result_r <= result_s;
      cycles_r <= cycles_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end
endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: directed vector table, handshake corner
// sequences and randomized pairs against a Euclid-based reference.
module tb_gcd_stein;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int MAX_CYC = 4 * WIDTH + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  gcd_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gcd_stein #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] exp_res;
    int          exp_cyc;   // 0 = latency not pinned
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // One request; checks handshake shape and returns result and cycle count.
  task automatic run(input logic [31:0] x, input logic [31:0] y, input bit poke,
                     output logic [31:0] res, output int cyc);
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1    = x;
    bus.n2    = y;
    @(negedge clk);
    bus.start = 1'b0;
    edges     = 1;
    chk("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    if (poke) begin
      bus.start = 1'b1;
      bus.n1    = 32'd9;
      bus.n2    = 32'd3;
    end
    while (!bus.done && edges < 400) begin
      @(negedge clk);
      edges++;
      if (edges == 3) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("done_within_budget", {63'd0, bus.done}, 64'd1);
    res = bus.result;
    cyc = int'(bus.cycles);
    chk("cycles_vs_edges", 64'(bus.cycles), 64'(edges));
    chk("cycles_bound", {63'd0, (cyc <= MAX_CYC)}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
    chk("idle_after_done", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, x, y, g;
    logic [63:0] lcm;
    int          cyc;
    bit          saw_done;

    bus.start = 1'b1;
    bus.n1    = 32'd12;
    bus.n2    = 32'd8;

    // Reset held with start high: nothing accepted
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cycles", 64'(bus.cycles), 64'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{32'd0, 32'd5, 32'd5, 2});
    vecs.push_back('{32'd0, 32'd0, 32'd0, 2});
    vecs.push_back('{32'd9, 32'd0, 32'd9, 2});
    vecs.push_back('{32'd7, 32'd7, 32'd7, 6});
    vecs.push_back('{32'd48, 32'd18, 32'd6, 0});
    vecs.push_back('{32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 0});
    vecs.push_back('{32'd35, 32'd64, 32'd1, 0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 32'd1, 0});
    foreach (vecs[i]) begin
      run(vecs[i].n1, vecs[i].n2, 1'b0, res, cyc);
      chk($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
      if (vecs[i].exp_cyc != 0) chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
    end

    // start pulsed while busy with other operands is ignored
    run(32'd21, 32'd14, 1'b1, res, cyc);
    chk("busy_start_ignored", 64'(res), 64'd7);

    // Mid-run reset: no done, outputs cleared, next request fine
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1    = 32'h8000_0000;
    bus.n2    = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_cycles", 64'(bus.cycles), 64'd0);
    saw_done = bus.done;
    repeat (150) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
    end
    chk("midrst_no_done", {63'd0, saw_done}, 64'd0);
    run(32'd48, 32'd18, 1'b0, res, cyc);
    chk("after_rst_result", 64'(res), 64'd6);

    // start held through DONE: re-accepted on the edge after leaving DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.n1    = 32'd0;
    bus.n2    = 32'd9;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_first_done", {63'd0, bus.done}, 64'd1);
    @(negedge clk);
    chk("b2b_idle_gap", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk("b2b_reaccept", {63'd0, bus.busy}, 64'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_second_done", {63'd0, bus.done}, 64'd1);
    chk("b2b_second_result", 64'(bus.result), 64'd9);
    @(negedge clk);

    // Random pairs with shared power-of-two factors and occasional zeros
    for (int i = 0; i < 300; i++) begin
      x = $urandom() >> $urandom_range(0, 31);
      y = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) begin
        x = x << $urandom_range(0, 8);
        y = y << $urandom_range(0, 8);
      end
      if ($urandom_range(0, 40) == 0) x = 32'd0;
      run(x, y, 1'b0, res, cyc);
      g = ref_gcd(x, y);
      chk($sformatf("rand%0d_gcd(%0h,%0h)", i, x, y), 64'(res), 64'(g));
      if (res != 32'd0) begin
        lcm = (64'(x) / 64'(res)) * 64'(y);
        chk($sformatf("rand%0d_gcd_lcm", i), 64'(res) * lcm, 64'(x) * 64'(y));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
